// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multi-cycle MIPS control unit.
// Holds opcode values, ALUOp / ALUSrcB / PCSource encodings, the fixed FSM
// state encodings (exposed on state_o for debug) and a small state helper.
package multicycle_control_pkg;

    // Instruction opcodes (bits [31:26] of the instruction word)
    localparam logic [5:0] OP_R_TYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_J      = 6'b000010;

    // ALU-control selector
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b11;

    // ALU B-operand mux
    localparam logic [1:0] SRC_B_RT      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR    = 2'b01;
    localparam logic [1:0] SRC_B_IMM     = 2'b10;
    localparam logic [1:0] SRC_B_IMM_SL2 = 2'b11;

    // PC source mux
    localparam logic [1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

    // FSM state encodings; these values are visible on state_o
    localparam int unsigned STATE_W = 4;
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_FETCH    = 4'd1;
    localparam logic [3:0] ST_DECODE   = 4'd2;
    localparam logic [3:0] ST_MEM_ADDR = 4'd3;
    localparam logic [3:0] ST_MEM_RD   = 4'd4;
    localparam logic [3:0] ST_MEM_WB   = 4'd5;
    localparam logic [3:0] ST_MEM_WR   = 4'd6;
    localparam logic [3:0] ST_R_EXE    = 4'd7;
    localparam logic [3:0] ST_R_WB     = 4'd8;
    localparam logic [3:0] ST_I_EXE    = 4'd9;
    localparam logic [3:0] ST_I_WB     = 4'd10;
    localparam logic [3:0] ST_BRANCH   = 4'd11;
    localparam logic [3:0] ST_JUMP     = 4'd12;

    // States that own the shared memory port and run the wait counter
    function automatic logic is_mem_state(input logic [3:0] st);
        return (st == ST_FETCH) || (st == ST_MEM_RD) || (st == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit.
// Sequences each instruction through FETCH / DECODE / execute / memory /
// write-back states, drives the datapath muxes and enables, and handshakes
// with a variable-latency shared I/D memory port with an optional timeout.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             CPU runs while high (sampled on entry to FETCH)
//   op_i                opcode from IR, valid from DECODE onward
//   zero_i              ALU zero flag (gated into the PC in the datapath)
//   mem_ready_i         memory completes the current request this cycle
//   mem_req_o/mem_we_o  memory request / write qualifier
//   iord_o              memory address select (0 PC, 1 ALUOut)
//   ir_write_o, pc_write_o, pc_write_cond_o, pc_source_o
//   alu_src_a_o, alu_src_b_o, alu_op_o
//   reg_dst_o, reg_write_o, mem_to_reg_o
//   state_o             current state (debug)
//   err_o               one-cycle pulse: illegal opcode or memory timeout
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned OP_W        = 6,
    parameter int unsigned ALUOP_W     = 2,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [OP_W-1:0]    op_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic               iord_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pc_source_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               reg_dst_o,
    output logic               reg_write_o,
    output logic               mem_to_reg_o,
    output logic [3:0]         state_o,
    output logic               err_o
);

    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    logic [3:0]       r_state;
    logic [3:0]       w_state_next;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_next;
    logic             r_fetch_issued;  // FETCH request already on the port
    logic             w_fetch_issued_next;

    logic w_mem_state;
    logic w_req;
    logic w_done;
    logic w_timeout;
    logic w_illegal;

    // The branch decision (zero_i & pc_write_cond_o) is made in the datapath;
    // the flag is part of the interface only.
    logic w_unused_zero;
    assign w_unused_zero = zero_i;

    // Memory handshake
    always_comb begin
        w_mem_state = is_mem_state(r_state);
        w_req       = 1'b0;
        if (r_state == ST_FETCH) begin
            // start_i only gates a fetch that has not been issued yet
            w_req = r_fetch_issued | start_i;
        end else if (w_mem_state) begin
            w_req = 1'b1;
        end
        w_done    = w_req & mem_ready_i;
        // A completing cycle beats a timeout on the same cycle
        w_timeout = (MEM_TIMEOUT != 0) && w_req && !mem_ready_i
                    && (r_wait_cnt == TIMEOUT_VAL);
    end

    // Wait counter: restarts on every entry to a memory state, saturates so a
    // disabled timeout never wraps.
    always_comb begin
        w_wait_cnt_next = '0;
        if (w_req && !w_done && !w_timeout) begin
            w_wait_cnt_next = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + 1'b1;
        end
        w_fetch_issued_next = (r_state == ST_FETCH) && w_req && !w_done && !w_timeout;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        w_illegal    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (!w_req) begin
                    w_state_next = ST_IDLE;
                end else if (w_done) begin
                    w_state_next = ST_DECODE;
                end
                // timeout re-enters FETCH; the counter and issue flag clear
            end
            ST_DECODE: begin
                case (op_i)
                    OP_W'(OP_R_TYPE): w_state_next = ST_R_EXE;
                    OP_W'(OP_ADDI):   w_state_next = ST_I_EXE;
                    OP_W'(OP_LW),
                    OP_W'(OP_SW):     w_state_next = ST_MEM_ADDR;
                    OP_W'(OP_BEQ):    w_state_next = ST_BRANCH;
                    OP_W'(OP_J):      w_state_next = ST_JUMP;
                    default: begin
                        w_state_next = ST_FETCH;
                        w_illegal    = 1'b1;
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                w_state_next = (op_i == OP_W'(OP_SW)) ? ST_MEM_WR : ST_MEM_RD;
            end
            ST_MEM_RD: begin
                if (w_done) begin
                    w_state_next = ST_MEM_WB;
                end else if (w_timeout) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_MEM_WR: begin
                if (w_done || w_timeout) w_state_next = ST_FETCH;
            end
            ST_R_EXE:  w_state_next = ST_R_WB;
            ST_I_EXE:  w_state_next = ST_I_WB;
            ST_MEM_WB,
            ST_R_WB,
            ST_I_WB,
            ST_BRANCH,
            ST_JUMP:   w_state_next = ST_FETCH;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        iord_o          = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_source_o     = PC_SRC_ALU;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRC_B_RT;
        alu_op_o        = ALUOP_W'(ALUOP_ADD);
        reg_dst_o       = 1'b0;
        reg_write_o     = 1'b0;
        mem_to_reg_o    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_req_o   = w_req;
                alu_src_b_o = SRC_B_FOUR;
                // PC+4 and IR latch only on the completing cycle
                ir_write_o  = w_done;
                pc_write_o  = w_done;
            end
            ST_DECODE: begin
                alu_src_b_o = SRC_B_IMM_SL2;
            end
            ST_MEM_ADDR, ST_I_EXE: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRC_B_IMM;
            end
            ST_MEM_RD: begin
                mem_req_o = 1'b1;
                iord_o    = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                iord_o    = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            ST_R_EXE: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_W'(ALUOP_FUNCT);
            end
            ST_R_WB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            ST_I_WB: begin
                reg_write_o = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALUOP_W'(ALUOP_SUB);
                pc_write_cond_o = 1'b1;
                pc_source_o     = PC_SRC_ALUOUT;
            end
            ST_JUMP: begin
                pc_write_o  = 1'b1;
                pc_source_o = PC_SRC_JUMP;
            end
            default: begin
            end
        endcase
        state_o = r_state;
        err_o   = w_timeout | w_illegal;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_wait_cnt     <= '0;
            r_fetch_issued <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_wait_cnt     <= w_wait_cnt_next;
            r_fetch_issued <= w_fetch_issued_next;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control (MEM_TIMEOUT = 4).
// Each row drives {rst, start, mem_ready, zero} for one cycle and gives the
// state and output vector expected in that cycle.
module tb_multicycle_control;

    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DEC = 4'd2,   S_MADDR = 4'd3;
    localparam logic [3:0] S_MRD  = 4'd4,  S_MWB   = 4'd5,  S_MWR = 4'd6,   S_REXE  = 4'd7;
    localparam logic [3:0] S_RWB  = 4'd8,  S_IEXE  = 4'd9,  S_IWB = 4'd10,  S_BR    = 4'd11;
    localparam logic [3:0] S_JMP  = 4'd12;

    // {req, we, iord, irw, pcw, pcwc, pcsrc[2], srca, srcb[2], aluop[2], rdst, rwr, m2r, err}
    localparam logic [16:0] O_IDLE     = 17'b0_0_0_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] O_F_RDY    = 17'b1_0_0_1_1_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] O_F_WAIT   = 17'b1_0_0_0_0_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] O_F_TMO    = 17'b1_0_0_0_0_0_00_0_01_00_0_0_0_1;
    localparam logic [16:0] O_F_OFF    = 17'b0_0_0_0_0_0_00_0_01_00_0_0_0_0;
    localparam logic [16:0] O_DEC      = 17'b0_0_0_0_0_0_00_0_11_00_0_0_0_0;
    localparam logic [16:0] O_DEC_ERR  = 17'b0_0_0_0_0_0_00_0_11_00_0_0_0_1;
    localparam logic [16:0] O_MADDR    = 17'b0_0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [16:0] O_MRD      = 17'b1_0_1_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] O_MWR      = 17'b1_1_1_0_0_0_00_0_00_00_0_0_0_0;
    localparam logic [16:0] O_MWR_TMO  = 17'b1_1_1_0_0_0_00_0_00_00_0_0_0_1;
    localparam logic [16:0] O_MWB      = 17'b0_0_0_0_0_0_00_0_00_00_0_1_1_0;
    localparam logic [16:0] O_REXE     = 17'b0_0_0_0_0_0_00_1_00_11_0_0_0_0;
    localparam logic [16:0] O_RWB      = 17'b0_0_0_0_0_0_00_0_00_00_1_1_0_0;
    localparam logic [16:0] O_IEXE     = 17'b0_0_0_0_0_0_00_1_10_00_0_0_0_0;
    localparam logic [16:0] O_IWB      = 17'b0_0_0_0_0_0_00_0_00_00_0_1_0_0;
    localparam logic [16:0] O_BR       = 17'b0_0_0_0_0_1_01_1_00_01_0_0_0_0;
    localparam logic [16:0] O_JMP      = 17'b0_0_0_0_1_0_10_0_00_00_0_0_0_0;

    typedef struct packed {
        logic [3:0]  ctl;  // {rst, start, mem_ready, zero}
        logic [3:0]  st;
        logic [16:0] o;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_i, start_i, zero_i, mem_ready_i;
    logic [5:0]  op_i;
    logic        mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o;
    logic [1:0]  pc_source_o, alu_src_b_o, alu_op_o;
    logic        alu_src_a_o, reg_dst_o, reg_write_o, mem_to_reg_o, err_o;
    logic [3:0]  state_o;
    logic [16:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .OP_W        (6),
        .ALUOP_W     (2),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .op_i            (op_i),
        .zero_i          (zero_i),
        .mem_ready_i     (mem_ready_i),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .iord_o          (iord_o),
        .ir_write_o      (ir_write_o),
        .pc_write_o      (pc_write_o),
        .pc_write_cond_o (pc_write_cond_o),
        .pc_source_o     (pc_source_o),
        .alu_src_a_o     (alu_src_a_o),
        .alu_src_b_o     (alu_src_b_o),
        .alu_op_o        (alu_op_o),
        .reg_dst_o       (reg_dst_o),
        .reg_write_o     (reg_write_o),
        .mem_to_reg_o    (mem_to_reg_o),
        .state_o         (state_o),
        .err_o           (err_o)
    );

    assign outs = {mem_req_o, mem_we_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o,
                   pc_source_o, alu_src_a_o, alu_src_b_o, alu_op_o,
                   reg_dst_o, reg_write_o, mem_to_reg_o, err_o};

    // Leaves the DUT in IDLE at 1 time unit after a rising edge
    task automatic do_reset();
        rst_i = 1'b1; start_i = 1'b0; mem_ready_i = 1'b0; zero_i = 1'b0; op_i = 6'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    task automatic drive(input logic [3:0] ctl);
        {rst_i, start_i, mem_ready_i, zero_i} = ctl;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows [$];
        rows = '{'{4'b0010, S_IDLE, O_IDLE}, '{4'b0011, S_IDLE, O_IDLE}};
        do_reset();
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].ctl);
            n_cmp++;
            if (state_o !== rows[i].st) begin
                n_err++;
                $display("FAIL reset[%0d] state_o: got %0d, expected %0d", i, state_o, rows[i].st);
            end
            n_cmp++;
            if (outs !== rows[i].o) begin
                n_err++;
                $display("FAIL reset[%0d] outputs: got %b, expected %b", i, outs, rows[i].o);
            end
            next_cycle();
        end
    endtask

    task automatic test_rtype();
        row_t rows [$];
        rows = '{'{4'b0110, S_IDLE, O_IDLE}, '{4'b0110, S_FETCH, O_F_RDY},
                 '{4'b0110, S_DEC, O_DEC},   '{4'b0110, S_REXE, O_REXE},
                 '{4'b0110, S_RWB, O_RWB},   '{4'b0110, S_FETCH, O_F_RDY}};
        do_reset();
        op_i = 6'b000000;
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].ctl);
            n_cmp++;
            if (state_o !== rows[i].st) begin
                n_err++;
                $display("FAIL rtype[%0d] state_o: got %0d, expected %0d", i, state_o, rows[i].st);
            end
            n_cmp++;
            if (outs !== rows[i].o) begin
                n_err++;
                $display("FAIL rtype[%0d] outputs: got %b, expected %b", i, outs, rows[i].o);
            end
            next_cycle();
        end
    endtask

    task automatic test_addi();
        row_t rows [$];
        rows = '{'{4'b0110, S_IDLE, O_IDLE}, '{4'b0110, S_FETCH, O_F_RDY},
                 '{4'b0110, S_DEC, O_DEC},   '{4'b0110, S_IEXE, O_IEXE},
                 '{4'b0110, S_IWB, O_IWB},   '{4'b0110, S_FETCH, O_F_RDY}};
        do_reset();
        op_i = 6'b001000;
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].ctl);
            n_cmp++;
            if (state_o !== rows[i].st) begin
                n_err++;
                $display("FAIL addi[%0d] state_o: got %0d, expected %0d", i, state_o, rows[i].st);
            end
            n_cmp++;
            if (outs !== rows[i].o) begin
                n_err++;
                $display("FAIL addi[%0d] outputs: got %b, expected %b", i, outs, rows[i].o);
            end
            next_cycle();
        end
    endtask

    // lw with memory completing on the third request cycle in FETCH and MEM_RD
    task automatic test_lw_slow_mem();
        row_t rows [$];
        int   ir_pulses = 0;
        rows = '{'{4'b0100, S_IDLE, O_IDLE},   '{4'b0100, S_FETCH, O_F_WAIT},
                 '{4'b0100, S_FETCH, O_F_WAIT}, '{4'b0110, S_FETCH, O_F_RDY},
                 '{4'b0100, S_DEC, O_DEC},      '{4'b0100, S_MADDR, O_MADDR},
                 '{4'b0100, S_MRD, O_MRD},      '{4'b0100, S_MRD, O_MRD},
                 '{4'b0110, S_MRD, O_MRD},      '{4'b0100, S_MWB, O_MWB},
                 '{4'b0110, S_FETCH, O_F_RDY}};
        do_reset();
        op_i = 6'b100011;
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].ctl);
            if (i >= 1 && i <= 9 && ir_write_o === 1'b1) ir_pulses++;
            n_cmp++;
            if (state_o !== rows[i].st) begin
                n_err++;
                $display("FAIL lw[%0d] state_o: got %0d, expected %0d", i, state_o, rows[i].st);
            end
            n_cmp++;
            if (outs !== rows[i].o) begin
                n_err++;
                $display("FAIL lw[%0d] outputs: got %b, expected %b", i, outs, rows[i].o);
            end
            next_cycle();
        end
        n_cmp++;
        if (ir_pulses !== 1) begin
            n_err++;
            $display("FAIL lw ir_write pulses: got %0d, expected 1", ir_pulses);
        end
    endtask

    // beq taken then not taken: control outputs do not depend on zero_i
    task automatic test_branch();
        row_t rows [$];
        rows = '{'{4'b0111, S_IDLE, O_IDLE}, '{4'b0111, S_FETCH, O_F_RDY},
                 '{4'b0111, S_DEC, O_DEC},   '{4'b0111, S_BR, O_BR},
                 '{4'b0110, S_FETCH, O_F_RDY}, '{4'b0110, S_DEC, O_DEC},
                 '{4'b0110, S_BR, O_BR},     '{4'b0110, S_FETCH, O_F_RDY}};
        do_reset();
        op_i = 6'b000100;
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].ctl);
            n_cmp++;
            if (state_o !== rows[i].st) begin
                n_err++;
                $display("FAIL beq[%0d] state_o: got %0d, expected %0d", i, state_o, rows[i].st);
            end
            n_cmp++;
            if (outs !== rows[i].o) begin
                n_err++;
                $display("FAIL beq[%0d] outputs: got %b, expected %b", i, outs, rows[i].o);
            end
            next_cycle();
        end
    endtask

    task automatic test_jump();
        row_t rows [$];
        rows = '{'{4'b0110, S_IDLE, O_IDLE}, '{4'b0110, S_FETCH, O_F_RDY},
                 '{4'b0110, S_DEC, O_DEC},   '{4'b0110, S_JMP, O_JMP},
                 '{4'b0110, S_FETCH, O_F_RDY}};
        do_reset();
        op_i = 6'b000010;
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].ctl);
            n_cmp++;
            if (state_o !== rows[i].st) begin
                n_err++;
                $display("FAIL jump[%0d] state_o: got %0d, expected %0d", i, state_o, rows[i].st);
            end
            n_cmp++;
            if (outs !== rows[i].o) begin
                n_err++;
                $display("FAIL jump[%0d] outputs: got %b, expected %b", i, outs, rows[i].o);
            end
            next_cycle();
        end
    endtask

    task automatic test_illegal();
        row_t rows [$];
        rows = '{'{4'b0110, S_IDLE, O_IDLE},    '{4'b0110, S_FETCH, O_F_RDY},
                 '{4'b0110, S_DEC, O_DEC_ERR},  '{4'b0100, S_FETCH, O_F_WAIT},
                 '{4'b0100, S_FETCH, O_F_WAIT}};
        do_reset();
        op_i = 6'b111111;
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].ctl);
            n_cmp++;
            if (state_o !== rows[i].st) begin
                n_err++;
                $display("FAIL illegal[%0d] state_o: got %0d, expected %0d", i, state_o, rows[i].st);
            end
            n_cmp++;
            if (outs !== rows[i].o) begin
                n_err++;
                $display("FAIL illegal[%0d] outputs: got %b, expected %b", i, outs, rows[i].o);
            end
            next_cycle();
        end
    endtask

    // sw timeout, FETCH timeout, then sw with ready arriving on the timeout cycle
    task automatic test_timeout();
        row_t rows [$];
        rows = '{'{4'b0110, S_IDLE, O_IDLE},    '{4'b0110, S_FETCH, O_F_RDY},
                 '{4'b0100, S_DEC, O_DEC},      '{4'b0100, S_MADDR, O_MADDR},
                 '{4'b0100, S_MWR, O_MWR},      '{4'b0100, S_MWR, O_MWR},
                 '{4'b0100, S_MWR, O_MWR},      '{4'b0100, S_MWR, O_MWR},
                 '{4'b0100, S_MWR, O_MWR_TMO},  '{4'b0100, S_FETCH, O_F_WAIT},
                 '{4'b0100, S_FETCH, O_F_WAIT}, '{4'b0100, S_FETCH, O_F_WAIT},
                 '{4'b0100, S_FETCH, O_F_WAIT}, '{4'b0100, S_FETCH, O_F_TMO},
                 '{4'b0110, S_FETCH, O_F_RDY},  '{4'b0100, S_DEC, O_DEC},
                 '{4'b0100, S_MADDR, O_MADDR},  '{4'b0100, S_MWR, O_MWR},
                 '{4'b0100, S_MWR, O_MWR},      '{4'b0100, S_MWR, O_MWR},
                 '{4'b0100, S_MWR, O_MWR},      '{4'b0110, S_MWR, O_MWR},
                 '{4'b0110, S_FETCH, O_F_RDY}};
        do_reset();
        op_i = 6'b101011;
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].ctl);
            n_cmp++;
            if (state_o !== rows[i].st) begin
                n_err++;
                $display("FAIL timeout[%0d] state_o: got %0d, expected %0d", i, state_o, rows[i].st);
            end
            n_cmp++;
            if (outs !== rows[i].o) begin
                n_err++;
                $display("FAIL timeout[%0d] outputs: got %b, expected %b", i, outs, rows[i].o);
            end
            next_cycle();
        end
    endtask

    // start_i dropped during an issued fetch and mid-instruction; stop at next FETCH
    task automatic test_start_low();
        row_t rows [$];
        rows = '{'{4'b0100, S_IDLE, O_IDLE},    '{4'b0100, S_FETCH, O_F_WAIT},
                 '{4'b0000, S_FETCH, O_F_WAIT}, '{4'b0010, S_FETCH, O_F_RDY},
                 '{4'b0000, S_DEC, O_DEC},      '{4'b0000, S_REXE, O_REXE},
                 '{4'b0000, S_RWB, O_RWB},      '{4'b0010, S_FETCH, O_F_OFF},
                 '{4'b0010, S_IDLE, O_IDLE},    '{4'b0000, S_IDLE, O_IDLE}};
        do_reset();
        op_i = 6'b000000;
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].ctl);
            n_cmp++;
            if (state_o !== rows[i].st) begin
                n_err++;
                $display("FAIL start_low[%0d] state_o: got %0d, expected %0d", i, state_o, rows[i].st);
            end
            n_cmp++;
            if (outs !== rows[i].o) begin
                n_err++;
                $display("FAIL start_low[%0d] outputs: got %b, expected %b", i, outs, rows[i].o);
            end
            next_cycle();
        end
    endtask

    // Reset while MEM_RD holds the request, then a clean lw
    task automatic test_reset_mid();
        row_t rows [$];
        rows = '{'{4'b0110, S_IDLE, O_IDLE},   '{4'b0110, S_FETCH, O_F_RDY},
                 '{4'b0100, S_DEC, O_DEC},     '{4'b0100, S_MADDR, O_MADDR},
                 '{4'b1100, S_MRD, O_MRD},     '{4'b0110, S_IDLE, O_IDLE},
                 '{4'b0110, S_FETCH, O_F_RDY}, '{4'b0100, S_DEC, O_DEC},
                 '{4'b0100, S_MADDR, O_MADDR}, '{4'b0100, S_MRD, O_MRD},
                 '{4'b0110, S_MRD, O_MRD},     '{4'b0110, S_MWB, O_MWB},
                 '{4'b0110, S_FETCH, O_F_RDY}};
        do_reset();
        op_i = 6'b100011;
        for (int i = 0; i < rows.size(); i++) begin
            drive(rows[i].ctl);
            n_cmp++;
            if (state_o !== rows[i].st) begin
                n_err++;
                $display("FAIL reset_mid[%0d] state_o: got %0d, expected %0d", i, state_o, rows[i].st);
            end
            n_cmp++;
            if (outs !== rows[i].o) begin
                n_err++;
                $display("FAIL reset_mid[%0d] outputs: got %b, expected %b", i, outs, rows[i].o);
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_addi();
        test_lw_slow_mem();
        test_branch();
        test_jump();
        test_illegal();
        test_timeout();
        test_start_low();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
